// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and bit-period helper for uart_tx/uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  localparam int TIMER_W   = 32;
  localparam int DATA_BITS = 8;

  function automatic int bit_limit(input int clkfreq, input int baudrate);
    return clkfreq / baudrate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and line/status signals of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] din_i;
  logic                 din_valid_i;
  logic                 din_ready_o;
  logic                 tx_o;
  logic                 busy_o;
  logic                 tx_done_o;

  modport master (
    output din_i, din_valid_i,
    input  din_ready_o, tx_o, busy_o, tx_done_o
  );

  modport slave (
    input  din_i, din_valid_i,
    output din_ready_o, tx_o, busy_o, tx_done_o
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BITLIM-1, flags the last cycle and wraps; held at zero by clr.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BITLIM = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(BITLIM - 1);

  logic [TIMER_W-1:0] count;

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || tc) begin
      count <= '0;
    end else begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB-first, 1 or 2 stop bits, with a one-entry holding register.
// state   | meaning
// S_IDLE  | line high, waiting for a held byte
// S_START | start bit (low) on the line
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit(s) high; chains straight into S_START when a byte is held
module uart_tx
  import uart_pkg::*;
#(
  parameter int clkfreq  = 100_000_000,
  parameter int baudrate = 115_200,
  parameter int stopbits = 1
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);

  localparam int         BITLIM    = bit_limit(clkfreq, baudrate);
  localparam logic [2:0] STOP_LAST = 3'(stopbits - 1);

  if (stopbits != 1 && stopbits != 2) begin : g_bad_stopbits
    $error("uart_tx: stopbits must be 1 or 2");
  end

  uart_state_t          state_q, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_valid_q;
  logic [2:0]           bit_cnt_q, bit_cnt_n;
  logic                 tx_q, tx_n;
  logic                 load;
  logic                 accept;
  logic                 done;
  logic                 bit_end;

  uart_bit_timer #(
    .BITLIM(BITLIM)
  ) u_bit_timer (
    .clk(clk),
    .rst(rst),
    .clr(state_q == S_IDLE),
    .tc (bit_end)
  );

  assign accept = bus.din_valid_i && !hold_valid_q;

  // Accept wins over load so a byte written on the load edge is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (accept) begin
      hold_valid_q <= 1'b1;
      hold_q       <= bus.din_i;
    end else if (load) begin
      hold_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      bit_cnt_q <= bit_cnt_n;
      tx_q      <= tx_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    bit_cnt_n = bit_cnt_q;
    tx_n      = tx_q;
    load      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_n      = 1'b1;
        bit_cnt_n = '0;
        if (hold_valid_q) begin
          load    = 1'b1;
          shift_n = hold_q;
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_n      = shift_q[0];
          bit_cnt_n = '0;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_n = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            tx_n    = 1'b1;
            state_n = S_STOP;
          end else begin
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            done      = 1'b1;
            bit_cnt_n = '0;
            if (hold_valid_q) begin
              load    = 1'b1;
              shift_n = hold_q;
              tx_n    = 1'b0;
              state_n = S_START;
            end else begin
              tx_n    = 1'b1;
              state_n = S_IDLE;
            end
          end else begin
            bit_cnt_n = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.din_ready_o = !hold_valid_q;
  assign bus.tx_o        = tx_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.tx_done_o   = done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model compared every cycle, plus directed literal checks.
module tb_uart_tx;

  localparam int CLKF = 800;
  localparam int BAUD = 100;
  localparam int BL   = 8;
  localparam int HN   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if b0 ();
  uart_tx_if b1 ();

  logic [7:0] d_din [2];
  logic [1:0] d_valid;
  logic [1:0] o_tx, o_busy, o_rdy, o_done;

  assign b0.din_i       = d_din[0];
  assign b0.din_valid_i = d_valid[0];
  assign b1.din_i       = d_din[1];
  assign b1.din_valid_i = d_valid[1];
  assign o_tx[0]   = b0.tx_o;
  assign o_busy[0] = b0.busy_o;
  assign o_rdy[0]  = b0.din_ready_o;
  assign o_done[0] = b0.tx_done_o;
  assign o_tx[1]   = b1.tx_o;
  assign o_busy[1] = b1.busy_o;
  assign o_rdy[1]  = b1.din_ready_o;
  assign o_done[1] = b1.tx_done_o;

  uart_tx #(.clkfreq(CLKF), .baudrate(BAUD), .stopbits(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  uart_tx #(.clkfreq(CLKF), .baudrate(BAUD), .stopbits(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s dut%0d actual=%0d required=%0d at cycle %0d", name, k, act, exp, cyc);
    end
  endtask

  // Model: position within the current frame (-1 when idle), plus the holding slot.
  int         m_pos [2] = '{-1, -1};
  logic [7:0] m_cur [2] = '{8'h00, 8'h00};
  bit         m_hv  [2] = '{1'b0, 1'b0};
  logic [7:0] m_hd  [2] = '{8'h00, 8'h00};

  function automatic int flen(input int k);
    return (9 + k + 1) * BL;
  endfunction

  function automatic int exp_tx(input int k);
    int idx;
    if (m_pos[k] < 0) return 1;
    idx = m_pos[k] / BL;
    if (idx == 0) return 0;
    if (idx <= 8) return int'(m_cur[k][idx-1]);
    return 1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int         np;
    logic [7:0] ncur;
    bit         nhv;
    logic [7:0] nhd;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_pos[k] <= -1;
        m_hv[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        np   = m_pos[k];
        ncur = m_cur[k];
        nhv  = m_hv[k];
        nhd  = m_hd[k];
        if (np >= 0) begin
          np = np + 1;
          if (np == flen(k)) begin
            if (nhv) begin
              np = 0; ncur = nhd; nhv = 1'b0;
            end else begin
              np = -1;
            end
          end
        end else if (nhv) begin
          np = 0; ncur = nhd; nhv = 1'b0;
        end
        if (d_valid[k] && !m_hv[k]) begin
          nhv = 1'b1; nhd = d_din[k];
        end
        m_pos[k] <= np;
        m_cur[k] <= ncur;
        m_hv[k]  <= nhv;
        m_hd[k]  <= nhd;
      end
    end
  end

  logic hist_tx   [2][HN];
  logic hist_busy [2][HN];
  int   done_at   [2][16];
  int   start_at  [2][16];
  int   done_cnt  [2] = '{0, 0};
  int   start_cnt [2] = '{0, 0};
  logic prev_busy [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check("tx", k, int'(o_tx[k]), exp_tx(k));
      check("busy", k, int'(o_busy[k]), int'(m_pos[k] >= 0));
      check("ready", k, int'(o_rdy[k]), int'(!m_hv[k]));
      check("done", k, int'(o_done[k]), int'(m_pos[k] == flen(k) - 1));
      if (cyc < HN) begin
        hist_tx[k][cyc]   = o_tx[k];
        hist_busy[k][cyc] = o_busy[k];
      end
      if (o_done[k] && done_cnt[k] < 16) begin
        done_at[k][done_cnt[k]] = cyc;
        done_cnt[k]++;
      end
      if (o_busy[k] && !prev_busy[k] && start_cnt[k] < 16) begin
        start_at[k][start_cnt[k]] = cyc;
        start_cnt[k]++;
      end
      prev_busy[k] = o_busy[k];
    end
  end

  task automatic send(input int k, input logic [7:0] b, output int acc_cyc);
    bit r;
    r = 1'b0;
    @(negedge clk);
    d_din[k]   = b;
    d_valid[k] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r = o_rdy[k];
      @(posedge clk);
      if (r) break;
      @(negedge clk);
    end
    #1;
    acc_cyc    = cyc;
    d_valid[k] = 1'b0;
    check("accepted", k, int'(r), 1);
  endtask

  task automatic wait_done(input int k, input int target);
    for (int n = 0; n < 400 && done_cnt[k] < target; n++) @(negedge clk);
    check("done_seen", k, int'(done_cnt[k] >= target), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_levels(input string name, input int k, input int st, input bit lv[11], input int nbits);
    int nbad;
    for (int i = 0; i < nbits; i++) begin
      nbad = 0;
      for (int j = 0; j < BL; j++)
        if (hist_tx[k][st + BL*i + j] !== lv[i]) nbad++;
      check(name, i, nbad, 0);
    end
  endtask

  bit lv_a5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
  bit lv_81 [11] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};

  initial begin : stim
    int acc, a1, a2, a3, st, dc, sc, nlow, nbusy;
    logic [7:0] byte_rx;
    d_valid  = '0;
    d_din[0] = 8'h00;
    d_din[1] = 8'h00;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 0, int'(o_tx[0]), 1);
    check("rst_ready", 0, int'(o_rdy[0]), 1);
    check("rst_busy", 0, int'(o_busy[0]), 0);
    check("rst_done", 0, int'(o_done[0]), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_tx", 0, int'(o_tx[0]), 1);
    check("idle_busy", 1, int'(o_busy[1]), 0);
    check("idle_starts", 0, start_cnt[0], 0);

    // Single byte 0xA5
    sc = start_cnt[0];
    dc = done_cnt[0];
    send(0, 8'hA5, acc);
    wait_done(0, dc + 1);
    st = start_at[0][sc];
    check("a5_latency", 0, st - acc, 1);
    check_levels("a5_level", 0, st, lv_a5, 10);
    check("a5_done_cycle", 0, done_at[0][dc] - st + 1, 80);
    check("a5_busy_last", 0, int'(hist_busy[0][done_at[0][dc]]), 1);
    check("a5_busy_drop", 0, int'(hist_busy[0][done_at[0][dc] + 1]), 0);

    // Back-to-back 0x00 then 0xFF
    dc = done_cnt[0];
    send(0, 8'h00, a1);
    send(0, 8'hFF, a2);
    wait_done(0, dc + 2);
    check("b2b_accept_in_frame", 0, int'(a2 < done_at[0][dc]), 1);
    check("b2b_done_gap", 0, done_at[0][dc + 1] - done_at[0][dc], 80);
    check("b2b_no_gap_tx", 0, int'(hist_tx[0][done_at[0][dc] + 1]), 0);
    check("b2b_no_gap_busy", 0, int'(hist_busy[0][done_at[0][dc] + 1]), 1);

    // Backpressure: holding full, 0x3C offered until taken
    dc = done_cnt[0];
    send(0, 8'h11, a1);
    send(0, 8'h22, a2);
    send(0, 8'h3C, a3);
    check("bp_accept_cycle", 0, a3 - done_at[0][dc], 2);
    wait_done(0, dc + 3);
    st = done_at[0][dc + 1] + 1;
    for (int i = 0; i < 8; i++) byte_rx[i] = hist_tx[0][st + 4 + BL*(i + 1)];
    check("bp_byte", 0, int'(byte_rx), 8'h3C);

    // Two stop bits, 0x81
    sc = start_cnt[1];
    dc = done_cnt[1];
    send(1, 8'h81, acc);
    wait_done(1, dc + 1);
    st = start_at[1][sc];
    check("sb2_latency", 1, st - acc, 1);
    check_levels("sb2_level", 1, st, lv_81, 11);
    check("sb2_frame", 1, done_at[1][dc] - st + 1, 88);

    // Reset during data bit 3 with a byte queued
    sc = start_cnt[0];
    dc = done_cnt[0];
    send(0, 8'h55, a1);
    send(0, 8'h66, a2);
    @(negedge clk);
    st = start_at[0][sc];
    for (int n = 0; n < 400 && cyc < st + 35; n++) @(negedge clk);
    check("mid_pre_tx", 0, int'(o_tx[0]), 0);
    check("mid_pre_ready", 0, int'(o_rdy[0]), 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx", 0, int'(o_tx[0]), 1);
    check("mid_rst_busy", 0, int'(o_busy[0]), 0);
    check("mid_rst_ready", 0, int'(o_rdy[0]), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a3 = cyc;
    repeat (100) @(negedge clk);
    nlow  = 0;
    nbusy = 0;
    for (int c = a3 + 1; c <= a3 + 99; c++) begin
      if (hist_tx[0][c] !== 1'b1) nlow++;
      if (hist_busy[0][c] !== 1'b0) nbusy++;
    end
    check("mid_quiet_tx", 0, nlow, 0);
    check("mid_quiet_busy", 0, nbusy, 0);
    check("mid_no_done", 0, done_cnt[0], dc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
